regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
Write-side companion of the 16x32 register file. It accepts retiring results (destination index plus data) from the pipeline through a valid/ready handshake and buffers them in a small in-order queue. It drives the register file write port (WEn/RDest/WData) with at most one write per cycle. It also gives the decode stage a bypass lookup, so reads never return stale values while writes are still pending.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
AW, 4, register index width
DW, 32, data width

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  asynchronous active-low reset
InValid  input  1  result offered
InReady  output  1  queue can accept
InDest  input  AW  destination register index
InData  input  DW  result data
Stall  input  1  1 = hold the queue, no pop this cycle
WEn  output  1  register file write enable
RDest  output  AW  register file write index
WData  output  DW  register file write data
RInA  input  AW  lookup index A (same index as register file read port A)
RInB  input  AW  lookup index B
BypA  output  1  pending write to RInA exists
BypDataA  output  DW  youngest pending data for RInA
BypB  output  1  pending write to RInB exists
BypDataB  output  DW  youngest pending data for RInB
Count  output  clog2(DEPTH+1)  occupied queue entries
Empty  output  1  Count==0

Behaviour:
- Reset is asynchronous on RSTn low and takes effect immediately. Count=0, Empty=1, WEn=0, RDest=0, WData=0, pointers=0, InReady=1, BypA=BypB=0, BypDataA=BypDataB=0. All pending writes are discarded, including when reset arrives mid-stream.
- Handshake: a transfer occurs on the rising edge where InValid && InReady. InReady = (Count<DEPTH), computed from registered state only and never from InValid.
- If InDest==0 on a transfer, the write is accepted (handshake completes) but not enqueued; R0 is never written.
- Pop: on each edge where Stall==0 and Count>0, the head entry loads into WEn=1/RDest/WData and the read pointer advances. On any other edge WEn loads 0; RDest/WData hold their last values.
- There is no fall-through. An entry pushed at edge N pops at edge N+1 at the earliest. WEn is high during cycle N+1..N+2, and the register file captures it at edge N+2.
- Push and pop on the same edge: both happen and Count is unchanged.
- Push into a full queue cannot happen, because InReady=0.
- Pointers wrap modulo DEPTH.
- Count updates: push-only +1, pop-only -1, both or neither unchanged.
- Bypass is combinational from registered state. The candidates are the valid queue entries plus the output register when WEn=1.
- BypX=1 if any candidate destination equals RInX and RInX!=0. BypDataX is the data of the youngest matching candidate. Age order runs from youngest to oldest: queue tail-1 ... head, then the output register.
- With no match, BypX=0 and BypDataX=0.
- A result being pushed in the current cycle is not visible to bypass until the following cycle.
- Stall has no effect on pushes; a stalled queue fills and then deasserts InReady.

Test Plan:
1. Reset: hold RSTn=0 for 2 cycles -> WEn=0, Count=0, Empty=1, InReady=1, BypA=BypB=0. Pulse RSTn low between clock edges -> outputs clear immediately.
2. Single write: push InDest=2, InData=7 at edge1, Stall=0 -> WEn=1, RDest=2, WData=7 for exactly one cycle after edge2. With RInA=2, BypA=1 and BypDataA=7 after edge1, clearing after edge3.
3. Fill/stall: Stall=1, push R1..R5 on consecutive edges with data 0x10..0x50 -> Count=4 and InReady=0 after 4th push, 5th held off. Then Stall=0 -> writes R1..R4 appear in order, one per cycle, and the 5th is accepted the edge after the first pop.
4. Youngest bypass: Stall=1, push R5=0x11 then R5=0x22 -> RInA=5 gives BypA=1, BypDataA=0x22. RInB=6 gives BypB=0, BypDataB=0.
5. R0 drop: push InDest=0, InData=0xFFFF -> handshake completes, Count stays 0, WEn never asserts. RInA=0 gives BypA=0.
6. Simultaneous push/pop with wrap: Stall=0, push every cycle for 10 cycles -> Count stays 1, WEn stays high, and the RDest/WData sequence matches the input order across pointer wrap.

Source files
------------

// File: rtl/regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_writeback                                             |
// | Purpose  : Write-side companion of the register file. Retiring results   |
// |            (dest index + data) are accepted over a valid/ready handshake,|
// |            buffered in an in-order queue and drained one per cycle into  |
// |            the register file write port. A two-port bypass lookup lets   |
// |            decode see the youngest pending value for any register.       |
// | Ports    : CLK, RSTn (async active-low)                                  |
// |            InValid/InReady/InDest/InData : result input handshake        |
// |            Stall                         : hold the queue (no pop)       |
// |            WEn/RDest/WData               : register file write port      |
// |            RInA/RInB -> BypA/BypDataA, BypB/BypDataB : bypass lookups    |
// |            Count/Empty                   : queue occupancy               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [AW-1:0]                InDest,
  input  logic [DW-1:0]                InData,
  input  logic                         Stall,
  output logic                         WEn,
  output logic [AW-1:0]                RDest,
  output logic [DW-1:0]                WData,
  input  logic [AW-1:0]                RInA,
  input  logic [AW-1:0]                RInB,
  output logic                         BypA,
  output logic [DW-1:0]                BypDataA,
  output logic                         BypB,
  output logic [DW-1:0]                BypDataB,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] dest_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          wen_q;
  logic [AW-1:0] rdest_q;
  logic [DW-1:0] wdata_q;

  logic w_push;
  logic w_pop;

  // Ready depends only on registered occupancy, never on InValid.
  assign InReady = (count_q < CW'(DEPTH));
  // Writes to R0 complete the handshake but are dropped here.
  assign w_push  = InValid && InReady && (InDest != '0);
  assign w_pop   = !Stall && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      rdest_q <= '0;
      wdata_q <= '0;
    end else begin
      count_q <= count_d;
      if (w_push) begin
        dest_q[wptr_q] <= InDest;
        data_q[wptr_q] <= InData;
        wptr_q         <= wptr_q + PW'(1);
      end
      // RDest/WData keep their last values when nothing pops.
      if (w_pop) begin
        wen_q   <= 1'b1;
        rdest_q <= dest_q[rptr_q];
        wdata_q <= data_q[rptr_q];
        rptr_q  <= rptr_q + PW'(1);
      end else begin
        wen_q   <= 1'b0;
      end
    end
  end

  // Candidates are scanned oldest first (output register, then head..tail-1)
  // so that a later match overrides and the youngest match wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] idx);
    logic          hit;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    hit = 1'b0;
    d   = '0;
    if (wen_q && (rdest_q == idx)) begin
      hit = 1'b1;
      d   = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      p = rptr_q + PW'(i);
      if ((CW'(i) < count_q) && (dest_q[p] == idx)) begin
        hit = 1'b1;
        d   = data_q[p];
      end
    end
    if (idx == '0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {BypA, BypDataA} = lookup(RInA);
    {BypB, BypDataB} = lookup(RInB);
  end

  assign WEn   = wen_q;
  assign RDest = rdest_q;
  assign WData = wdata_q;
  assign Count = count_q;
  assign Empty = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_writeback                                          |
// | Purpose  : Self-checking bench for regfile_writeback against a queue     |
// |            based reference model; directed scenarios then random traffic.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic          CLK;
  logic          RSTn;
  logic          InValid;
  logic          InReady;
  logic [AW-1:0] InDest;
  logic [DW-1:0] InData;
  logic          Stall;
  logic          WEn;
  logic [AW-1:0] RDest;
  logic [DW-1:0] WData;
  logic [AW-1:0] RInA;
  logic [AW-1:0] RInB;
  logic          BypA;
  logic [DW-1:0] BypDataA;
  logic          BypB;
  logic [DW-1:0] BypDataB;
  logic [2:0]    Count;
  logic          Empty;

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .InValid(InValid), .InReady(InReady), .InDest(InDest), .InData(InData),
    .Stall(Stall),
    .WEn(WEn), .RDest(RDest), .WData(WData),
    .RInA(RInA), .RInB(RInB),
    .BypA(BypA), .BypDataA(BypDataA), .BypB(BypB), .BypDataB(BypDataB),
    .Count(Count), .Empty(Empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: pending writes in arrival order plus the write port.
  typedef struct packed {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } ent_t;

  ent_t          q[$];
  logic          mwen;
  logic [AW-1:0] mrdest;
  logic [DW-1:0] mwdata;

  int ncmp  = 0;
  int nfail = 0;

  function automatic logic [DW:0] mbyp(input logic [AW-1:0] idx);
    if (idx == '0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].d == idx) return {1'b1, q[i].v};
    if (mwen && (mrdest == idx)) return {1'b1, mwdata};
    return '0;
  endfunction

  task automatic model_clear();
    q.delete();
    mwen   = 1'b0;
    mrdest = '0;
    mwdata = '0;
  endtask

  task automatic model_edge();
    bit   rdy;
    bit   pushing;
    bit   popping;
    ent_t e;
    rdy     = (q.size() < DEPTH);
    pushing = InValid && rdy && (InDest != 0);
    popping = !Stall && (q.size() > 0);
    if (popping) begin
      e      = q.pop_front();
      mwen   = 1'b1;
      mrdest = e.d;
      mwdata = e.v;
    end else begin
      mwen   = 1'b0;
    end
    if (pushing) q.push_back('{d: InDest, v: InData});
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [DW:0] ea;
    logic [DW:0] eb;
    ea = mbyp(RInA);
    eb = mbyp(RInB);
    chk({ph, ".count"},   DW'(Count),    DW'(q.size()));
    chk({ph, ".empty"},   DW'(Empty),    DW'(q.size() == 0));
    chk({ph, ".inready"}, DW'(InReady),  DW'(q.size() < DEPTH));
    chk({ph, ".wen"},     DW'(WEn),      DW'(mwen));
    chk({ph, ".rdest"},   DW'(RDest),    DW'(mrdest));
    chk({ph, ".wdata"},   WData,         mwdata);
    chk({ph, ".bypa"},    DW'(BypA),     DW'(ea[DW]));
    chk({ph, ".bypdataa"}, BypDataA,     ea[DW-1:0]);
    chk({ph, ".bypb"},    DW'(BypB),     DW'(eb[DW]));
    chk({ph, ".bypdatab"}, BypDataB,     eb[DW-1:0]);
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then compare all outputs shortly after the edge.
  task automatic step(input string ph);
    @(posedge CLK);
    if (!RSTn) model_clear();
    else       model_edge();
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string ph);
    #2;
    RSTn = 1'b0;
    #1;
    model_clear();
    check_all(ph);
    #1;
    RSTn = 1'b1;
  endtask

  task automatic drain(input string ph);
    InValid = 1'b0;
    Stall   = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) step(ph);
  endtask

  initial begin
    RSTn    = 1'b0;
    InValid = 1'b0;
    InDest  = '0;
    InData  = '0;
    Stall   = 1'b0;
    RInA    = '0;
    RInB    = '0;
    model_clear();

    // Reset held for two cycles.
    step("rst0");
    step("rst1");
    chk("rst.wen_const",  DW'(WEn), 0);
    chk("rst.empty_const", DW'(Empty), 1);
    RSTn = 1'b1;

    // Single write with bypass visibility.
    RInA    = 4'd2;
    RInB    = 4'd3;
    InValid = 1'b1;
    InDest  = 4'd2;
    InData  = 32'd7;
    step("single.e1");
    chk("single.bypa_e1", BypDataA, 32'd7);
    InValid = 1'b0;
    step("single.e2");
    chk("single.wen_e2", DW'({WEn, RDest}), DW'({1'b1, 4'd2}));
    step("single.e3");
    chk("single.bypa_e3", DW'(BypA), 0);

    // Async reset pulse while a write is pending.
    InValid = 1'b1;
    InDest  = 4'd9;
    InData  = 32'hABCD;
    Stall   = 1'b1;
    step("prerst");
    InValid = 1'b0;
    async_reset("arst");
    Stall = 1'b0;
    step("postrst");

    // Fill while stalled; fifth result is held off.
    Stall   = 1'b1;
    InValid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      InDest = AW'(k);
      InData = DW'(k * 16);
      step("fill");
    end
    InDest = 4'd5;
    InData = 32'h50;
    step("fill.held");
    chk("fill.ready_low", DW'(InReady), 0);
    Stall = 1'b0;
    step("fill.pop1");
    chk("fill.first_out", DW'(RDest), 1);
    step("fill.pop2");
    InValid = 1'b0;
    for (int k = 0; k < 4; k++) step("fill.drain");

    // Youngest-match bypass.
    Stall   = 1'b1;
    InValid = 1'b1;
    InDest  = 4'd5;
    InData  = 32'h11;
    step("young.p1");
    InData  = 32'h22;
    step("young.p2");
    InValid = 1'b0;
    RInA    = 4'd5;
    RInB    = 4'd6;
    step("young.look");
    chk("young.bypdataa", BypDataA, 32'h22);
    drain("young.drain");

    // R0 results complete the handshake but never reach the write port.
    InValid = 1'b1;
    InDest  = 4'd0;
    InData  = 32'hFFFF;
    RInA    = 4'd0;
    #1;
    chk("r0.ready", DW'(InReady), 1);
    step("r0.push");
    InValid = 1'b0;
    step("r0.after");
    chk("r0.count", DW'(Count), 0);

    // Push every cycle with popping enabled: pointer wrap.
    Stall   = 1'b0;
    InValid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      InDest = AW'(1 + (k % 15));
      InData = 32'h100 + DW'(k);
      step("wrap");
    end
    InValid = 1'b0;
    step("wrap.tail");

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      InValid = ($urandom_range(0, 9) < 7);
      Stall   = ($urandom_range(0, 3) == 0);
      InDest  = AW'($urandom_range(0, 7));
      InData  = $urandom;
      RInA    = AW'($urandom_range(0, 7));
      RInB    = AW'($urandom_range(0, 7));
      step("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand.arst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
